// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared FSM state codes, owner encoding and RAM base default
package ram_arbiter_pkg;

  localparam logic [31:0] RAM_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_WR    = 3'd2;
  localparam logic [2:0] ST_WAITB = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

endpackage

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-outstanding fetch/load-store arbiter onto a RAM port
// ARB_ROUND_ROBIN_EN: alternate IF/MEM priority on conflicts instead of fixed MEM-first.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = RAM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid_i,
  output logic        if_req_ready_o,
  input  logic [31:0] if_addr_i,
  output logic        if_resp_valid_o,
  input  logic        if_resp_ready_i,
  output logic [63:0] if_rdata_o,
  input  logic        mem_req_valid_i,
  output logic        mem_req_ready_o,
  input  logic        mem_req_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [63:0] mem_wdata_i,
  input  logic [63:0] mem_wmask_i,
  output logic        mem_resp_valid_o,
  input  logic        mem_resp_ready_i,
  output logic [63:0] mem_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] ram_raddr_o,
  output logic        ram_ren_o,
  input  logic [63:0] ram_rdata_i,
  output logic [31:0] ram_waddr_o,
  output logic [63:0] ram_wdata_o,
  output logic [63:0] ram_wmask_o,
  output logic        ram_wen_o,
  input  logic        ram_bvalid_i
);

  logic [2:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] wmask_q, wmask_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        grant_mem;
  logic        grant_any;
  logic        owner_ready;
  logic [31:0] sel_addr;
  logic        sel_we;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // last_q records who won the previous conflict; the other side wins the next one
  assign grant_mem = mem_req_valid_i & (~if_req_valid_i | (last_q == OWNER_IF));

  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && if_req_valid_i && mem_req_valid_i) begin
      last_d = grant_mem ? OWNER_MEM : OWNER_IF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWNER_IF;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant_mem = mem_req_valid_i;
`endif

  assign grant_any   = if_req_valid_i | mem_req_valid_i;
  assign sel_addr    = grant_mem ? mem_addr_i : if_addr_i;
  assign sel_we      = grant_mem & mem_req_we_i;
  assign owner_ready = (owner_q == OWNER_MEM) ? mem_resp_ready_i : if_resp_ready_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          owner_d = grant_mem ? OWNER_MEM : OWNER_IF;
          addr_d  = sel_addr;
          wdata_d = grant_mem ? mem_wdata_i : '0;
          wmask_d = grant_mem ? mem_wmask_i : '0;
          rdata_d = '0;
          err_d   = (sel_addr < RAM_BASE);
          if (sel_addr < RAM_BASE) begin
            state_d = ST_ERR;
          end else if (sel_we) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        rdata_d = ram_rdata_i;
        state_d = ST_RESP;
      end
      ST_WR:    state_d = ST_WAITB;
      ST_WAITB: if (ram_bvalid_i) state_d = ST_RESP;
      ST_ERR:   state_d = ST_RESP;
      ST_RESP:  if (owner_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Ready is combinational from the request inputs, so it must be masked while reset is held
  assign mem_req_ready_o = rst & (state_q == ST_IDLE) & grant_mem;
  assign if_req_ready_o  = rst & (state_q == ST_IDLE) & if_req_valid_i & ~grant_mem;

  assign if_resp_valid_o  = (state_q == ST_RESP) & (owner_q == OWNER_IF);
  assign mem_resp_valid_o = (state_q == ST_RESP) & (owner_q == OWNER_MEM);
  assign if_rdata_o       = if_resp_valid_o  ? rdata_q : '0;
  assign mem_rdata_o      = mem_resp_valid_o ? rdata_q : '0;
  assign resp_err_o       = (state_q == ST_RESP) & err_q;

  assign ram_ren_o   = (state_q == ST_RD);
  assign ram_raddr_o = ram_ren_o ? addr_q : '0;
  assign ram_wen_o   = (state_q == ST_WR);
  assign ram_waddr_o = ram_wen_o ? addr_q : '0;
  assign ram_wdata_o = ram_wen_o ? wdata_q : '0;
  assign ram_wmask_o = ram_wen_o ? wmask_q : '0;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter RAM_BASE, default 32'h8000_0000, lowest legal RAM byte address.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_req_valid_i  input  1  fetch read request.
REQ-005 SHALL have port if_req_ready_o  output  1  fetch request accepted this cycle.
REQ-006 SHALL have port if_addr_i  input  32  fetch byte address.
REQ-007 SHALL have port if_resp_valid_o  output  1  fetch response valid.
REQ-008 SHALL have port if_resp_ready_i  input  1  fetch response consumed.
REQ-009 SHALL have port if_rdata_o  output  64  fetch read data.
REQ-010 SHALL have port mem_req_valid_i  input  1  load/store request.
REQ-011 SHALL have port mem_req_ready_o  output  1  load/store request accepted this cycle.
REQ-012 SHALL have port mem_req_we_i  input  1  1 = write, 0 = read.
REQ-013 SHALL have port mem_addr_i  input  32  load/store byte address.
REQ-014 SHALL have port mem_wdata_i  input  64  pre-shifted write data.
REQ-015 SHALL have port mem_wmask_i  input  64  bit write mask.
REQ-016 SHALL have port mem_resp_valid_o  output  1  load/store response valid; for writes it is the completion.
REQ-017 SHALL have port mem_resp_ready_i  input  1  load/store response consumed.
REQ-018 SHALL have port mem_rdata_o  output  64  load data; 0 for writes.
REQ-019 SHALL have port resp_err_o  output  1  error flag qualifying whichever resp_valid is high.
REQ-020 SHALL have ports ram_raddr_o (output, 32) and ram_ren_o (output, 1): RAM read address and read enable.
REQ-021 SHALL have port ram_rdata_i  input  64  RAM read data, combinational from ram_raddr_o.
REQ-022 SHALL have ports ram_waddr_o (output, 32), ram_wdata_o (output, 64), ram_wmask_o (output, 64) and ram_wen_o (output, 1): RAM write address, data, mask and write enable.
REQ-023 SHALL have port ram_bvalid_i  input  1  RAM write-complete pulse, one cycle after wen.

Function
REQ-024 SHALL implement the FSM IDLE -> {RD, WR, ERR} -> RESP -> IDLE, plus WR -> WAITB -> RESP.
REQ-025 In IDLE, SHALL grant one valid requester: pulse its req_ready for one cycle and register addr, we, wdata, wmask and the grant owner.
REQ-026 Both requests valid in IDLE: the MEM requester wins by fixed priority (see REQ-034 for the macro-enabled alternative).
REQ-027 Address < RAM_BASE: SHALL go to ERR with no RAM enable asserted, then RESP with resp_err_o=1 and rdata=0.
REQ-028 RD state: exactly one cycle with ram_ren_o=1 and ram_raddr_o=registered address; SHALL capture ram_rdata_i into the response register.
REQ-029 WR state: exactly one cycle with ram_wen_o=1 and registered waddr/wdata/wmask.
REQ-030 WAITB state: SHALL hold until ram_bvalid_i=1; a bvalid arriving in any other state SHALL be ignored.
REQ-031 RESP state: only the owner's resp_valid is high, with data stable, until the owner's resp_ready=1 in that cycle; then return to IDLE.
REQ-032 Latency, request accept to resp_valid: read 2 cycles, write 3 cycles, error 2 cycles; no new grant until RESP completes (one outstanding transaction).
REQ-033 ram_*_o outputs SHALL be 0 whenever their enable is low; the two resp_valid outputs are never high together.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN: when defined, a last-grant bit flips the priority on each IF/MEM conflict; when undefined, fixed MEM-first priority applies.

Reset
REQ-035 rst=0 SHALL force IDLE, clear the last-grant bit to IF, and drive all outputs to 0 immediately; a transaction in flight is dropped with no response.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, RAM_BASE default and the owner encoding; a single always_ff FSM is used with no sub-module.

Verification
REQ-037 IF read 0x8000_0008 with RAM word 0x1122_3344_5566_7788 -> if_resp_valid two cycles after accept, if_rdata_o=0x1122_3344_5566_7788, resp_err_o=0.
REQ-038 MEM write 0x8000_0010, wdata 0xFF, mask 0xFF -> ram_wen_o for one cycle, mem_resp_valid once bvalid arrives, then a read returns 0xFF in the low byte.
REQ-039 IF and MEM valid in the same cycle, repeated twice -> macro off: MEM, MEM; macro on: MEM then IF.
REQ-040 MEM read at 0x0000_1000 -> resp_err_o=1, mem_rdata_o=0, ram_ren_o and ram_wen_o never asserted.
REQ-041 resp_ready held low for 5 cycles -> resp_valid and data held stable and no new grant; a rst pulse in WAITB -> IDLE with all outputs 0.
